// File: rtl/iob_axi_ram_lat_pkg.sv
// iob_axi_ram_lat_pkg
// Shared definitions for the latency/throttling AXI4 memory slave:
// AXI burst encodings, response codes, read/write FSM state types and
// a helper that maps a burst type onto its response code.
package iob_axi_ram_lat_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rdState_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wrState_e;

  // The reserved burst encoding is still serviced (as INCR) but flagged.
  function automatic logic [1:0] burstResp(input logic [1:0] burst);
    return (burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/iob_axi_burst_addr.sv
// iob_axi_burst_addr
// Combinational next-word-address generator for one AXI burst beat.
// Ports:
//   addr_i  - current word address
//   len_i   - AXI burst length (beats - 1)
//   burst_i - AXI burst type
//   next_o  - word address of the following beat
module iob_axi_burst_addr
  import iob_axi_ram_lat_pkg::*;
#(
  parameter int AW = 22,
  parameter int LW = 8
) (
  input  logic [AW-1:0] addr_i,
  input  logic [LW-1:0] len_i,
  input  logic [1:0]    burst_i,
  output logic [AW-1:0] next_o
);

  logic [AW-1:0] incrAddr;
  logic [AW-1:0] wrapMask;

  // WRAP lengths are 2/4/8/16 beats, so len itself is the low-bit mask of
  // the aligned wrap block: upper bits stay put, lower bits increment.
  always_comb begin
    incrAddr = addr_i + AW'(1);
    wrapMask = AW'(len_i);
    case (burst_i)
      BURST_FIXED: next_o = addr_i;
      BURST_WRAP:  next_o = (addr_i & ~wrapMask) | (incrAddr & wrapMask);
      default:     next_o = incrAddr;
    endcase
  end

endmodule

// File: rtl/iob_axi_ram_lat.sv
// iob_axi_ram_lat
// AXI4 slave memory model front end with programmable read latency and a
// rotating ready-throttle pattern. Drives an external two-port RAM
// (registered read, byte-enabled write) through the ext_mem_* bus.
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   axi_ar* / axi_r*          - AXI read address / read data channels
//   axi_aw* / axi_w* / axi_b* - AXI write address / data / response channels
//   ext_mem_*                 - external RAM read and write ports
module iob_axi_ram_lat
  import iob_axi_ram_lat_pkg::*;
#(
  parameter int         ID_WIDTH   = 4,
  parameter int         ADDR_WIDTH = 24,
  parameter int         DATA_WIDTH = 32,
  parameter int         LEN_WIDTH  = 8,
  parameter int         RD_LAT     = 4,
  parameter logic [7:0] STALL_MASK = 8'hFF,
  localparam int        STRB_W     = DATA_WIDTH / 8,
  localparam int        BYTE_W     = $clog2(STRB_W),
  localparam int        WADDR_W    = ADDR_WIDTH - BYTE_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ID_WIDTH-1:0]   axi_arid_i,
  input  logic [ADDR_WIDTH-1:0] axi_araddr_i,
  input  logic [LEN_WIDTH-1:0]  axi_arlen_i,
  input  logic [2:0]            axi_arsize_i,
  input  logic [1:0]            axi_arburst_i,
  input  logic                  axi_arvalid_i,
  output logic                  axi_arready_o,
  output logic [ID_WIDTH-1:0]   axi_rid_o,
  output logic [DATA_WIDTH-1:0] axi_rdata_o,
  output logic [1:0]            axi_rresp_o,
  output logic                  axi_rlast_o,
  output logic                  axi_rvalid_o,
  input  logic                  axi_rready_i,
  input  logic [ID_WIDTH-1:0]   axi_awid_i,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr_i,
  input  logic [LEN_WIDTH-1:0]  axi_awlen_i,
  input  logic [2:0]            axi_awsize_i,
  input  logic [1:0]            axi_awburst_i,
  input  logic                  axi_awvalid_i,
  output logic                  axi_awready_o,
  input  logic [DATA_WIDTH-1:0] axi_wdata_i,
  input  logic [STRB_W-1:0]     axi_wstrb_i,
  input  logic                  axi_wlast_i,
  input  logic                  axi_wvalid_i,
  output logic                  axi_wready_o,
  output logic [ID_WIDTH-1:0]   axi_bid_o,
  output logic [1:0]            axi_bresp_o,
  output logic                  axi_bvalid_o,
  input  logic                  axi_bready_i,
  output logic                  ext_mem_clk_o,
  output logic                  ext_mem_r_en_o,
  output logic [WADDR_W-1:0]    ext_mem_r_addr_o,
  input  logic [DATA_WIDTH-1:0] ext_mem_r_data_i,
  output logic [STRB_W-1:0]     ext_mem_w_strb_o,
  output logic [WADDR_W-1:0]    ext_mem_w_addr_o,
  output logic [DATA_WIDTH-1:0] ext_mem_w_data_o
);

  // Size fields, wlast and byte-offset bits play no role: every beat is full width.
  logic unusedInputs;
  assign unusedInputs = ^{axi_arsize_i, axi_awsize_i, axi_wlast_i, axi_araddr_i, axi_awaddr_i};

  logic [2:0] stallCnt_q;
  logic       gate;

  rdState_e             rdState_q, rdState_d;
  logic [ID_WIDTH-1:0]  rdId_q, rdId_d;
  logic [WADDR_W-1:0]   rdAddr_q, rdAddr_d, rdNext;
  logic [LEN_WIDTH-1:0] rdLen_q, rdLen_d, rdBeat_q, rdBeat_d;
  logic [1:0]           rdBurst_q, rdBurst_d;
  logic [7:0]           latCnt_q, latCnt_d;
  logic                 rValid_q, rValid_d;

  wrState_e             wrState_q, wrState_d;
  logic [ID_WIDTH-1:0]  wrId_q, wrId_d;
  logic [WADDR_W-1:0]   wrAddr_q, wrAddr_d, wrNext;
  logic [LEN_WIDTH-1:0] wrLen_q, wrLen_d, wrBeat_q, wrBeat_d;
  logic [1:0]           wrBurst_q, wrBurst_d;

  iob_axi_burst_addr #(.AW(WADDR_W), .LW(LEN_WIDTH)) rdAddrGen (
    .addr_i (rdAddr_q),
    .len_i  (rdLen_q),
    .burst_i(rdBurst_q),
    .next_o (rdNext)
  );

  iob_axi_burst_addr #(.AW(WADDR_W), .LW(LEN_WIDTH)) wrAddrGen (
    .addr_i (wrAddr_q),
    .len_i  (wrLen_q),
    .burst_i(wrBurst_q),
    .next_o (wrNext)
  );

  // Free-running throttle index shared by both channels; the gate is also
  // forced low while reset is held so no handshake is advertised then.
  always_ff @(posedge clk_i) begin
    if (rst_i) stallCnt_q <= '0;
    else       stallCnt_q <= stallCnt_q + 3'd1;
  end

  assign gate = STALL_MASK[stallCnt_q] & ~rst_i;

  // Read FSM: wait out the latency, then issue one RAM read per accepted
  // beat. The read for the next beat is launched in the same cycle as the
  // current beat's handshake so data streams at one beat per cycle.
  always_comb begin
    rdState_d        = rdState_q;
    rdId_d           = rdId_q;
    rdAddr_d         = rdAddr_q;
    rdLen_d          = rdLen_q;
    rdBurst_d        = rdBurst_q;
    rdBeat_d         = rdBeat_q;
    latCnt_d         = latCnt_q;
    rValid_d         = rValid_q;
    axi_arready_o    = 1'b0;
    ext_mem_r_en_o   = 1'b0;
    ext_mem_r_addr_o = rdAddr_q;
    case (rdState_q)
      R_IDLE: begin
        axi_arready_o = gate;
        if (axi_arvalid_i && gate) begin
          rdId_d    = axi_arid_i;
          rdAddr_d  = axi_araddr_i[ADDR_WIDTH-1:BYTE_W];
          rdLen_d   = axi_arlen_i;
          rdBurst_d = axi_arburst_i;
          rdBeat_d  = '0;
          latCnt_d  = 8'(RD_LAT);
          rdState_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (latCnt_q == 8'd0) begin
          ext_mem_r_en_o = 1'b1;
          rValid_d       = 1'b1;
          rdState_d      = R_DATA;
        end else begin
          latCnt_d = latCnt_q - 8'd1;
        end
      end
      R_DATA: begin
        if (rValid_q && axi_rready_i) begin
          if (rdBeat_q == rdLen_q) begin
            rValid_d  = 1'b0;
            rdState_d = R_IDLE;
          end else begin
            ext_mem_r_en_o   = 1'b1;
            ext_mem_r_addr_o = rdNext;
            rdAddr_d         = rdNext;
            rdBeat_d         = rdBeat_q + LEN_WIDTH'(1);
          end
        end
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  // Read channel state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdState_q <= R_IDLE;
      rdId_q    <= '0;
      rdAddr_q  <= '0;
      rdLen_q   <= '0;
      rdBurst_q <= '0;
      rdBeat_q  <= '0;
      latCnt_q  <= '0;
      rValid_q  <= 1'b0;
    end else begin
      rdState_q <= rdState_d;
      rdId_q    <= rdId_d;
      rdAddr_q  <= rdAddr_d;
      rdLen_q   <= rdLen_d;
      rdBurst_q <= rdBurst_d;
      rdBeat_q  <= rdBeat_d;
      latCnt_q  <= latCnt_d;
      rValid_q  <= rValid_d;
    end
  end

  assign axi_rvalid_o = rValid_q;
  assign axi_rid_o    = rdId_q;
  assign axi_rdata_o  = ext_mem_r_data_i;
  assign axi_rlast_o  = rValid_q && (rdBeat_q == rdLen_q);
  assign axi_rresp_o  = rValid_q ? burstResp(rdBurst_q) : RESP_OKAY;

  // Write FSM: each accepted W beat goes straight to the RAM write port.
  // The burst ends on the beat count alone; wlast is not consulted.
  always_comb begin
    wrState_d        = wrState_q;
    wrId_d           = wrId_q;
    wrAddr_d         = wrAddr_q;
    wrLen_d          = wrLen_q;
    wrBurst_d        = wrBurst_q;
    wrBeat_d         = wrBeat_q;
    axi_awready_o    = 1'b0;
    axi_wready_o     = 1'b0;
    axi_bvalid_o     = 1'b0;
    ext_mem_w_strb_o = '0;
    case (wrState_q)
      W_IDLE: begin
        axi_awready_o = gate;
        if (axi_awvalid_i && gate) begin
          wrId_d    = axi_awid_i;
          wrAddr_d  = axi_awaddr_i[ADDR_WIDTH-1:BYTE_W];
          wrLen_d   = axi_awlen_i;
          wrBurst_d = axi_awburst_i;
          wrBeat_d  = '0;
          wrState_d = W_DATA;
        end
      end
      W_DATA: begin
        axi_wready_o = gate;
        if (axi_wvalid_i && gate) begin
          ext_mem_w_strb_o = axi_wstrb_i;
          wrAddr_d         = wrNext;
          wrBeat_d         = wrBeat_q + LEN_WIDTH'(1);
          if (wrBeat_q == wrLen_q) wrState_d = W_RESP;
        end
      end
      W_RESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) wrState_d = W_IDLE;
      end
      default: wrState_d = W_IDLE;
    endcase
  end

  // Write channel state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrState_q <= W_IDLE;
      wrId_q    <= '0;
      wrAddr_q  <= '0;
      wrLen_q   <= '0;
      wrBurst_q <= '0;
      wrBeat_q  <= '0;
    end else begin
      wrState_q <= wrState_d;
      wrId_q    <= wrId_d;
      wrAddr_q  <= wrAddr_d;
      wrLen_q   <= wrLen_d;
      wrBurst_q <= wrBurst_d;
      wrBeat_q  <= wrBeat_d;
    end
  end

  assign axi_bid_o        = wrId_q;
  assign axi_bresp_o      = (wrState_q == W_RESP) ? burstResp(wrBurst_q) : RESP_OKAY;
  assign ext_mem_w_addr_o = wrAddr_q;
  assign ext_mem_w_data_o = axi_wdata_i;
  assign ext_mem_clk_o    = clk_i;

endmodule

// File: tb/tb_iob_axi_ram_lat.sv
// tb_iob_axi_ram_lat
// Drives AXI bursts into iob_axi_ram_lat backed by a read-first RAM model,
// keeps a shadow copy of memory, and scoreboards R and B responses.
module tb_iob_axi_ram_lat;

  localparam int         RD_LAT = 4;
  localparam logic [7:0] STALL  = 8'h55;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [3:0]  arId, awId, rId, bId;
  logic [23:0] arAddr, awAddr;
  logic [7:0]  arLen, awLen;
  logic [2:0]  arSize, awSize;
  logic [1:0]  arBurst, awBurst, rResp, bResp;
  logic        arValid, arReady, awValid, awReady;
  logic [31:0] rData, wDataS;
  logic        rLast, rValid, rReady;
  logic [3:0]  wStrbS;
  logic        wLast, wValid, wReady;
  logic        bValid, bReady;
  logic        memClk, memREn;
  logic [21:0] memRAddr, memWAddr;
  logic [31:0] memRData = '0;
  logic [31:0] memWData;
  logic [3:0]  memWStrb;

  iob_axi_ram_lat #(
    .ID_WIDTH(4), .ADDR_WIDTH(24), .DATA_WIDTH(32), .LEN_WIDTH(8),
    .RD_LAT(RD_LAT), .STALL_MASK(STALL)
  ) dut (
    .clk_i(clock), .rst_i(reset),
    .axi_arid_i(arId), .axi_araddr_i(arAddr), .axi_arlen_i(arLen),
    .axi_arsize_i(arSize), .axi_arburst_i(arBurst), .axi_arvalid_i(arValid),
    .axi_arready_o(arReady),
    .axi_rid_o(rId), .axi_rdata_o(rData), .axi_rresp_o(rResp),
    .axi_rlast_o(rLast), .axi_rvalid_o(rValid), .axi_rready_i(rReady),
    .axi_awid_i(awId), .axi_awaddr_i(awAddr), .axi_awlen_i(awLen),
    .axi_awsize_i(awSize), .axi_awburst_i(awBurst), .axi_awvalid_i(awValid),
    .axi_awready_o(awReady),
    .axi_wdata_i(wDataS), .axi_wstrb_i(wStrbS), .axi_wlast_i(wLast),
    .axi_wvalid_i(wValid), .axi_wready_o(wReady),
    .axi_bid_o(bId), .axi_bresp_o(bResp), .axi_bvalid_o(bValid),
    .axi_bready_i(bReady),
    .ext_mem_clk_o(memClk), .ext_mem_r_en_o(memREn), .ext_mem_r_addr_o(memRAddr),
    .ext_mem_r_data_i(memRData), .ext_mem_w_strb_o(memWStrb),
    .ext_mem_w_addr_o(memWAddr), .ext_mem_w_data_o(memWData)
  );

  // Read-first RAM with registered read port, as the external RAM behaves.
  logic [31:0] ram    [0:1023] = '{default: '0};
  logic [31:0] shadow [0:1023] = '{default: '0};

  always @(posedge clock) begin
    if (memREn) memRData <= ram[memRAddr[9:0]];
    for (int b = 0; b < 4; b++)
      if (memWStrb[b]) ram[memWAddr[9:0]][8*b +: 8] <= memWData[8*b +: 8];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
    logic [3:0]  id;
  } rdItem_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bItem_t;

  rdItem_t rdQ[$];
  bItem_t  bQ[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] wBeatData [16];
  logic [3:0]  wBeatStrb [16];
  logic [7:0]  stallPat;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int nextWord(input int a, input int len, input logic [1:0] burst);
    int blk;
    case (burst)
      2'b00: return a;
      2'b10: begin
        blk = len + 1;
        return (a / blk) * blk + ((a % blk) + 1) % blk;
      end
      default: return a + 1;
    endcase
  endfunction

  // Ready signals must never be high in two consecutive cycles with 0x55.
  logic pAr = 1'b0, pAw = 1'b0, pW = 1'b0;
  always @(negedge clock) begin
    #2;
    if (reset) begin
      pAr = 1'b0; pAw = 1'b0; pW = 1'b0;
    end else begin
      checkOutput("noBackToBack", {arReady & pAr, awReady & pAw, wReady & pW}, 3'b000);
      pAr = arReady; pAw = awReady; pW = wReady;
    end
  end

  task automatic arSend(input logic [3:0] id, input logic [23:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, output int hsCyc);
    bit done = 0;
    arId = id; arAddr = addr; arLen = len; arBurst = burst; arSize = 3'd2; arValid = 1'b1;
    hsCyc = -1;
    for (int k = 0; k < 32 && !done; k++) begin
      #1;
      if (arReady) begin done = 1; hsCyc = cyc; end
      @(negedge clock);
    end
    arValid = 1'b0;
    if (!done) checkOutput("arTimeout", 0, 1);
  endtask

  task automatic awSend(input logic [3:0] id, input logic [23:0] addr, input logic [7:0] len,
                        input logic [1:0] burst);
    bit done = 0;
    awId = id; awAddr = addr; awLen = len; awBurst = burst; awSize = 3'd2; awValid = 1'b1;
    for (int k = 0; k < 32 && !done; k++) begin
      #1;
      if (awReady) done = 1;
      @(negedge clock);
    end
    awValid = 1'b0;
    if (!done) checkOutput("awTimeout", 0, 1);
  endtask

  task automatic writeBurst(input logic [3:0] id, input logic [23:0] addr, input int len,
                            input logic [1:0] burst);
    int a = int'(addr >> 2);
    bit got;
    bItem_t bi;
    awSend(id, addr, 8'(len), burst);
    for (int i = 0; i <= len; i++) begin
      wValid = 1'b1; wDataS = wBeatData[i]; wStrbS = wBeatStrb[i]; wLast = (i == len);
      got = 0;
      for (int k = 0; k < 32 && !got; k++) begin
        #1;
        if (wReady) begin
          got = 1;
          checkOutput("wMemAddr", memWAddr, 64'(a));
          checkOutput("wMemStrb", memWStrb, wBeatStrb[i]);
          for (int b = 0; b < 4; b++)
            if (wBeatStrb[i][b]) shadow[a % 1024][8*b +: 8] = wBeatData[i][8*b +: 8];
        end
        @(negedge clock);
      end
      if (!got) checkOutput("wTimeout", 0, 1);
      a = nextWord(a, len, burst);
    end
    wValid = 1'b0; wLast = 1'b0;
    #1;
    checkOutput("bNextCycle", bValid, 1);
    bi.id = id; bi.resp = (burst == 2'b11) ? 2'b10 : 2'b00;
    bQ.push_back(bi);
    got = 0;
    for (int k = 0; k < 32 && !got; k++) begin
      bReady = ($urandom_range(0, 3) != 0);
      #1;
      if (bValid && bReady) begin
        bi = bQ.pop_front();
        checkOutput("bId", bId, bi.id);
        checkOutput("bResp", bResp, bi.resp);
        got = 1;
      end
      @(negedge clock);
    end
    bReady = 1'b0;
    if (!got) begin checkOutput("bTimeout", 0, 1); bQ.delete(); end
  endtask

  task automatic readBurst(input logic [3:0] id, input logic [23:0] addr, input int len,
                           input logic [1:0] burst, input bit throttle);
    int a = int'(addr >> 2);
    int hs, first = -1, beats = 0;
    bit pV = 0, pR = 0;
    rdItem_t it;
    for (int i = 0; i <= len; i++) begin
      it.data = shadow[a % 1024]; it.last = (i == len);
      it.resp = (burst == 2'b11) ? 2'b10 : 2'b00; it.id = id;
      rdQ.push_back(it);
      a = nextWord(a, len, burst);
    end
    arSend(id, addr, 8'(len), burst, hs);
    for (int k = 0; k < 300 && beats <= len; k++) begin
      rReady = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (pV && !pR) checkOutput("rHold", rValid, 1);
      if (rValid && first < 0) begin
        first = cyc;
        checkOutput("rLatency", 64'(first - hs), 64'(RD_LAT + 2));
      end
      if (rValid && rReady) begin
        it = rdQ.pop_front();
        checkOutput("rData", rData, it.data);
        checkOutput("rLast", rLast, it.last);
        checkOutput("rResp", rResp, it.resp);
        checkOutput("rId", rId, it.id);
        beats++;
      end
      pV = rValid; pR = rReady;
      @(negedge clock);
    end
    rReady = 1'b0;
    if (beats <= len) begin checkOutput("rTimeout", 64'(beats), 64'(len + 1)); rdQ.delete(); end
  endtask

  // Pulse reset while beat 2 of a long read is being presented.
  task automatic resetMidRead();
    int hs, beats = 0;
    bit done = 0;
    arSend(4'hA, 24'h000100, 8'd7, 2'b01, hs);
    rReady = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      #1;
      if (rValid) begin
        if (beats == 2) begin rReady = 1'b0; reset = 1'b1; done = 1; end
        else beats++;
      end
      @(negedge clock);
    end
    if (!done) checkOutput("rstBeatTimeout", 0, 1);
    reset = 1'b0;
    #1;
    checkOutput("rstAbort", {rValid, rLast, memREn, bValid}, 4'b0000);
    checkOutput("rstIdleArReady", arReady, stallPat[0]);
    @(negedge clock);
  endtask

  task automatic applyStimulus();
    stallPat = STALL;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("resetOutputs",
                {arReady, awReady, wReady, rValid, bValid, rLast, memREn, memWStrb, rResp, bResp},
                15'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("stallSlot0", arReady, stallPat[0]);
    @(negedge clock);
    #1;
    checkOutput("stallSlot1", arReady, stallPat[1]);
    @(negedge clock);

    for (int i = 0; i < 4; i++) begin wBeatData[i] = 32'(i + 1); wBeatStrb[i] = 4'hF; end
    writeBurst(4'h3, 24'h000100, 3, 2'b01);
    readBurst(4'h5, 24'h000100, 3, 2'b01, 0);
    readBurst(4'h6, 24'h000108, 3, 2'b10, 1);

    wBeatData[0] = 32'h11; wBeatData[1] = 32'h22;
    writeBurst(4'h1, 24'h000200, 1, 2'b01);
    wBeatData[0] = 32'hA; wBeatData[1] = 32'hB; wBeatData[2] = 32'hC; wBeatData[3] = 32'hD;
    writeBurst(4'h2, 24'h000200, 3, 2'b00);
    readBurst(4'h7, 24'h000200, 1, 2'b01, 1);

    wBeatData[0] = 32'hDEADBEEF; wBeatStrb[0] = 4'b0101;
    writeBurst(4'h4, 24'h000200, 0, 2'b01);
    wBeatStrb[0] = 4'hF;
    readBurst(4'h4, 24'h000200, 0, 2'b01, 0);

    wBeatData[0] = 32'h77; wBeatData[1] = 32'h88;
    writeBurst(4'h8, 24'h000300, 1, 2'b11);
    readBurst(4'h8, 24'h000300, 1, 2'b11, 1);

    wBeatData[0] = 32'h5; wBeatData[1] = 32'h6;
    writeBurst(4'h9, 24'h000124, 1, 2'b10);
    readBurst(4'h9, 24'h000120, 1, 2'b01, 0);

    resetMidRead();
    rdQ.delete();
    readBurst(4'hB, 24'h000100, 7, 2'b01, 1);

    checkOutput("rdQEmpty", 64'(rdQ.size()), 0);
    checkOutput("bQEmpty", 64'(bQ.size()), 0);
  endtask

  initial begin
    arId = '0; arAddr = '0; arLen = '0; arSize = '0; arBurst = '0; arValid = 1'b0;
    awId = '0; awAddr = '0; awLen = '0; awSize = '0; awBurst = '0; awValid = 1'b0;
    wDataS = '0; wStrbS = '0; wLast = 1'b0; wValid = 1'b0;
    rReady = 1'b0; bReady = 1'b0;
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
